int_issue_queue: RTL and testbench

Collapsing issue queue between rename/dispatch and the integer execution unit. Buffers up to DEPTH decoded instructions and captures operand values from the writeback broadcast. Each cycle it presents the oldest instruction whose operands are all ready, with the field bundle the execution unit consumes. It is the producer side of the execution-unit operand interface and holds no result logic.

---
 rtl/int_issue_queue_pkg.sv | 41 ++++
 rtl/int_issue_queue_select.sv | 31 +++
 rtl/int_issue_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_int_issue_queue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue, dispatch and the execution unit.
package int_issue_queue_pkg;

  localparam int LREG_W        = 5;
  localparam int SRC_W         = 64;
  localparam int PC_W          = 64;
  localparam int INSTR_W       = 32;
  localparam int CX_TYPE_W     = 3;
  localparam int ALU_TYPE_W    = 4;
  localparam int MULDIV_TYPE_W = 3;
  localparam int SIZE_W        = 4;

  // Field bundle handed from dispatch to the queue and from the queue to execute.
  typedef struct packed {
    logic [LREG_W-1:0]        rs1;
    logic [LREG_W-1:0]        rs2;
    logic [LREG_W-1:0]        rd;
    logic [SRC_W-1:0]         src1;
    logic [SRC_W-1:0]         src2;
    logic [SRC_W-1:0]         offset;
    logic                     src1_is_reg;
    logic                     src2_is_reg;
    logic                     need_to_wb;
    logic [CX_TYPE_W-1:0]     cx_type;
    logic [ALU_TYPE_W-1:0]    alu_type;
    logic [MULDIV_TYPE_W-1:0] muldiv_type;
    logic                     is_load;
    logic                     is_store;
    logic [SIZE_W-1:0]        size;
    logic [PC_W-1:0]          pc;
    logic [INSTR_W-1:0]       instr;
  } isq_payload_t;

  // A writeback broadcast targets a source register; x0 never matches.
  function automatic logic wb_hit(input logic             wb_valid,
                                  input logic [LREG_W-1:0] wb_rd,
                                  input logic [LREG_W-1:0] rs);
    return wb_valid && (wb_rd != '0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/int_issue_queue_select.sv
// Oldest-ready priority picker with memory-ordering mask.
module isq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] rdy1_i,
  input  logic [DEPTH-1:0] rdy2_i,
  input  logic [DEPTH-1:0] mem_i,
  output logic [DEPTH-1:0] grant_o,
  output logic             any_o
);

  logic mem_seen;

  // Scan from oldest; a memory op is masked once an older memory op exists.
  always_comb begin
    // NOTE: blocking assignments here build a ripple chain through the loop;
    // every variable gets a default first so no latch is inferred.
    grant_o  = '0;
    any_o    = 1'b0;
    mem_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!any_o && valid_i[i] && rdy1_i[i] && rdy2_i[i] && !(mem_i[i] && mem_seen)) begin
        grant_o[i] = 1'b1;
        any_o      = 1'b1;
      end
      if (valid_i[i] && mem_i[i]) mem_seen = 1'b1;
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Collapsing integer issue queue: wakeup, oldest-ready select, shift-down on issue.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [LREG_W-1:0]        enq_rs1,
  input  logic [LREG_W-1:0]        enq_rs2,
  input  logic [LREG_W-1:0]        enq_rd,
  input  logic [SRC_W-1:0]         enq_src1,
  input  logic [SRC_W-1:0]         enq_src2,
  input  logic                     enq_src1_rdy,
  input  logic                     enq_src2_rdy,
  input  logic [SRC_W-1:0]         enq_offset,
  input  logic                     enq_src1_is_reg,
  input  logic                     enq_src2_is_reg,
  input  logic                     enq_need_to_wb,
  input  logic                     enq_is_load,
  input  logic                     enq_is_store,
  input  logic [CX_TYPE_W-1:0]     enq_cx_type,
  input  logic [ALU_TYPE_W-1:0]    enq_alu_type,
  input  logic [MULDIV_TYPE_W-1:0] enq_muldiv_type,
  input  logic [SIZE_W-1:0]        enq_size,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [INSTR_W-1:0]       enq_instr,
  input  logic                     wb_valid,
  input  logic [LREG_W-1:0]        wb_rd,
  input  logic [SRC_W-1:0]         wb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [LREG_W-1:0]        issue_rs1,
  output logic [LREG_W-1:0]        issue_rs2,
  output logic [LREG_W-1:0]        issue_rd,
  output logic [SRC_W-1:0]         issue_src1,
  output logic [SRC_W-1:0]         issue_src2,
  output logic [SRC_W-1:0]         issue_offset,
  output logic                     issue_src1_is_reg,
  output logic                     issue_src2_is_reg,
  output logic                     issue_need_to_wb,
  output logic [CX_TYPE_W-1:0]     issue_cx_type,
  output logic [ALU_TYPE_W-1:0]    issue_alu_type,
  output logic [MULDIV_TYPE_W-1:0] issue_muldiv_type,
  output logic                     issue_is_load,
  output logic                     issue_is_store,
  output logic [SIZE_W-1:0]        issue_size,
  output logic [PC_W-1:0]          issue_pc,
  output logic [INSTR_W-1:0]       issue_instr
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  isq_payload_t     pay_q [DEPTH];
  isq_payload_t     pay_d [DEPTH];

  isq_payload_t     wk_pay [DEPTH];
  logic [DEPTH-1:0] wk_rdy1, wk_rdy2;
  isq_payload_t     col_pay [DEPTH];
  logic [DEPTH-1:0] col_valid, col_rdy1, col_rdy2;
  logic             taken_below;
  logic             prev_valid;

  isq_payload_t     enq_pay;
  logic             enq_rdy1, enq_rdy2;
  logic [DEPTH-1:0] mem_vec;
  logic [DEPTH-1:0] grant;
  logic             any_ready;
  logic             enq_fire;
  logic             issue_fire;
  isq_payload_t     issue_pay;

  // Entries are contiguous from index 0, so the top slot being valid means full.
  assign enq_ready   = !valid_q[DEPTH-1];
  assign issue_valid = any_ready;
  assign enq_fire    = enq_valid && enq_ready && !flush;
  assign issue_fire  = any_ready && issue_ready && !flush;

  // Memory-op flags feeding the ordering mask.
  always_comb begin
    mem_vec = '0;
    for (int i = 0; i < DEPTH; i++) mem_vec[i] = pay_q[i].is_load || pay_q[i].is_store;
  end

  isq_select #(.DEPTH(DEPTH)) u_select (
    .valid_i (valid_q),
    .rdy1_i  (rdy1_q),
    .rdy2_i  (rdy2_q),
    .mem_i   (mem_vec),
    .grant_o (grant),
    .any_o   (any_ready)
  );

  // Build the incoming entry: x0 reads zero, and a same-cycle writeback is bypassed in.
  always_comb begin
    enq_pay = '{rs1: enq_rs1, rs2: enq_rs2, rd: enq_rd, src1: enq_src1, src2: enq_src2,
                offset: enq_offset, src1_is_reg: enq_src1_is_reg,
                src2_is_reg: enq_src2_is_reg, need_to_wb: enq_need_to_wb,
                cx_type: enq_cx_type, alu_type: enq_alu_type,
                muldiv_type: enq_muldiv_type, is_load: enq_is_load,
                is_store: enq_is_store, size: enq_size, pc: enq_pc, instr: enq_instr};
    enq_rdy1 = enq_src1_rdy || !enq_src1_is_reg || (enq_rs1 == '0);
    enq_rdy2 = enq_src2_rdy || !enq_src2_is_reg || (enq_rs2 == '0);
    if (enq_rs1 == '0) enq_pay.src1 = '0;
    if (enq_rs2 == '0) enq_pay.src2 = '0;
    if (!enq_rdy1 && wb_hit(wb_valid, wb_rd, enq_rs1)) begin
      enq_pay.src1 = wb_data;
      enq_rdy1     = 1'b1;
    end
    if (!enq_rdy2 && wb_hit(wb_valid, wb_rd, enq_rs2)) begin
      enq_pay.src2 = wb_data;
      enq_rdy2     = 1'b1;
    end
  end

  // Wakeup: waiting register operands capture a matching writeback.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk_pay[i]  = pay_q[i];
      wk_rdy1[i] = rdy1_q[i];
      wk_rdy2[i] = rdy2_q[i];
      if (valid_q[i] && !rdy1_q[i] && pay_q[i].src1_is_reg && wb_hit(wb_valid, wb_rd, pay_q[i].rs1)) begin
        wk_pay[i].src1 = wb_data;
        wk_rdy1[i]     = 1'b1;
      end
      if (valid_q[i] && !rdy2_q[i] && pay_q[i].src2_is_reg && wb_hit(wb_valid, wb_rd, pay_q[i].rs2)) begin
        wk_pay[i].src2 = wb_data;
        wk_rdy2[i]     = 1'b1;
      end
    end
  end

  // Collapse: at and above the issued slot, every entry moves down by one.
  always_comb begin
    taken_below = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      taken_below = taken_below | (issue_fire & grant[i]);
      if (taken_below) begin
        col_valid[i] = (i != DEPTH-1) && valid_q[(i+1) % DEPTH];
        col_pay[i]   = wk_pay[(i+1) % DEPTH];
        col_rdy1[i]  = wk_rdy1[(i+1) % DEPTH];
        col_rdy2[i]  = wk_rdy2[(i+1) % DEPTH];
      end else begin
        col_valid[i] = valid_q[i];
        col_pay[i]   = wk_pay[i];
        col_rdy1[i]  = wk_rdy1[i];
        col_rdy2[i]  = wk_rdy2[i];
      end
    end
  end

  // Enqueue into the first free slot after collapse; flush kills everything.
  always_comb begin
    prev_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = col_valid[i];
      pay_d[i]   = col_pay[i];
      rdy1_d[i]  = col_rdy1[i];
      rdy2_d[i]  = col_rdy2[i];
      if (enq_fire && !col_valid[i] && prev_valid) begin
        valid_d[i] = 1'b1;
        pay_d[i]   = enq_pay;
        rdy1_d[i]  = enq_rdy1;
        rdy2_d[i]  = enq_rdy2;
      end
      prev_valid = col_valid[i];
    end
    if (flush) valid_d = '0;
  end

  // Control state: valid and readiness flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  // Payload storage.
  // NOTE: the payload array is deliberately not reset; valid bits and the
  // one-hot grant keep stale contents from ever reaching an output.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) pay_q[i] <= pay_d[i];
  end

  // Present the granted entry; all-zero when nothing is selectable.
  always_comb begin
    issue_pay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) issue_pay = pay_q[i];
    end
  end

  assign issue_rs1         = issue_pay.rs1;
  assign issue_rs2         = issue_pay.rs2;
  assign issue_rd          = issue_pay.rd;
  assign issue_src1        = issue_pay.src1;
  assign issue_src2        = issue_pay.src2;
  assign issue_offset      = issue_pay.offset;
  assign issue_src1_is_reg = issue_pay.src1_is_reg;
  assign issue_src2_is_reg = issue_pay.src2_is_reg;
  assign issue_need_to_wb  = issue_pay.need_to_wb;
  assign issue_cx_type     = issue_pay.cx_type;
  assign issue_alu_type    = issue_pay.alu_type;
  assign issue_muldiv_type = issue_pay.muldiv_type;
  assign issue_is_load     = issue_pay.is_load;
  assign issue_is_store    = issue_pay.is_store;
  assign issue_size        = issue_pay.size;
  assign issue_pc          = issue_pay.pc;
  assign issue_instr       = issue_pay.instr;

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue: queue-based reference model plus directed scenarios.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic enq_valid = 1'b0;
  logic enq_ready;
  logic e_r1 = 1'b0, e_r2 = 1'b0;
  isq_payload_t e_pay = '0;
  logic wb_valid = 1'b0;
  logic [LREG_W-1:0] wb_rd = '0;
  logic [SRC_W-1:0] wb_data = '0;
  logic issue_valid;
  logic issue_ready = 1'b0;
  isq_payload_t dut_pay;

  logic [LREG_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic [SRC_W-1:0] issue_src1, issue_src2, issue_offset;
  logic issue_src1_is_reg, issue_src2_is_reg, issue_need_to_wb, issue_is_load, issue_is_store;
  logic [CX_TYPE_W-1:0] issue_cx_type;
  logic [ALU_TYPE_W-1:0] issue_alu_type;
  logic [MULDIV_TYPE_W-1:0] issue_muldiv_type;
  logic [SIZE_W-1:0] issue_size;
  logic [PC_W-1:0] issue_pc;
  logic [INSTR_W-1:0] issue_instr;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_count = 0;
  int hs_snap;

  always #5 clock = ~clock;

  int_issue_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_rs1(e_pay.rs1), .enq_rs2(e_pay.rs2), .enq_rd(e_pay.rd),
    .enq_src1(e_pay.src1), .enq_src2(e_pay.src2),
    .enq_src1_rdy(e_r1), .enq_src2_rdy(e_r2), .enq_offset(e_pay.offset),
    .enq_src1_is_reg(e_pay.src1_is_reg), .enq_src2_is_reg(e_pay.src2_is_reg),
    .enq_need_to_wb(e_pay.need_to_wb), .enq_is_load(e_pay.is_load), .enq_is_store(e_pay.is_store),
    .enq_cx_type(e_pay.cx_type), .enq_alu_type(e_pay.alu_type), .enq_muldiv_type(e_pay.muldiv_type),
    .enq_size(e_pay.size), .enq_pc(e_pay.pc), .enq_instr(e_pay.instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_offset(issue_offset),
    .issue_src1_is_reg(issue_src1_is_reg), .issue_src2_is_reg(issue_src2_is_reg),
    .issue_need_to_wb(issue_need_to_wb), .issue_cx_type(issue_cx_type),
    .issue_alu_type(issue_alu_type), .issue_muldiv_type(issue_muldiv_type),
    .issue_is_load(issue_is_load), .issue_is_store(issue_is_store),
    .issue_size(issue_size), .issue_pc(issue_pc), .issue_instr(issue_instr)
  );

  assign dut_pay = '{rs1: issue_rs1, rs2: issue_rs2, rd: issue_rd, src1: issue_src1,
                     src2: issue_src2, offset: issue_offset, src1_is_reg: issue_src1_is_reg,
                     src2_is_reg: issue_src2_is_reg, need_to_wb: issue_need_to_wb,
                     cx_type: issue_cx_type, alu_type: issue_alu_type,
                     muldiv_type: issue_muldiv_type, is_load: issue_is_load,
                     is_store: issue_is_store, size: issue_size, pc: issue_pc, instr: issue_instr};

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_pay(input string name, input isq_payload_t actual, input isq_payload_t expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: an ordered list of waiting instructions
  typedef struct {
    isq_payload_t p;
    logic         r1;
    logic         r2;
  } mentry_t;
  mentry_t mq[$];

  // Oldest entry with both operands ready, skipping memory ops behind an older memory op.
  function automatic int pick();
    bit mem_seen = 0;
    for (int i = 0; i < mq.size(); i++) begin
      bit is_mem = mq[i].p.is_load || mq[i].p.is_store;
      if (mq[i].r1 && mq[i].r2 && !(is_mem && mem_seen)) return i;
      if (is_mem) mem_seen = 1;
    end
    return -1;
  endfunction

  // Advance the model one clock edge using the inputs applied during that cycle.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      int c;
      bit enq_ok;
      mentry_t e;
      c = pick();
      enq_ok = enq_valid && (mq.size() < DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (!e.r1 && e.p.src1_is_reg && wb_valid && wb_rd != 0 && wb_rd == e.p.rs1) begin
          e.p.src1 = wb_data; e.r1 = 1;
        end
        if (!e.r2 && e.p.src2_is_reg && wb_valid && wb_rd != 0 && wb_rd == e.p.rs2) begin
          e.p.src2 = wb_data; e.r2 = 1;
        end
        mq[i] = e;
      end
      if (c >= 0 && issue_ready) mq.delete(c);
      if (enq_ok) begin
        e.p  = e_pay;
        e.r1 = e_r1 || !e_pay.src1_is_reg || e_pay.rs1 == 0;
        e.r2 = e_r2 || !e_pay.src2_is_reg || e_pay.rs2 == 0;
        if (e_pay.rs1 == 0) e.p.src1 = 0;
        if (e_pay.rs2 == 0) e.p.src2 = 0;
        if (!e.r1 && wb_valid && wb_rd != 0 && wb_rd == e_pay.rs1) begin e.p.src1 = wb_data; e.r1 = 1; end
        if (!e.r2 && wb_valid && wb_rd != 0 && wb_rd == e_pay.rs2) begin e.p.src2 = wb_data; e.r2 = 1; end
        mq.push_back(e);
      end
    end
  end

  // Compare DUT outputs with the model every cycle, mid-cycle.
  always @(negedge clock) begin
    int c;
    c = pick();
    check("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
    check("issue_valid", 64'(issue_valid), 64'(c >= 0));
    if (c >= 0) check_pay("issue_payload", dut_pay, mq[c].p);
    else if (!reset_n) check_pay("reset_payload", dut_pay, '0);
    if (issue_valid && issue_ready && !flush) hs_count++;
  end

  // ---------------- stimulus helpers
  function automatic isq_payload_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [63:0] s1, input logic [63:0] s2,
                                      input logic ld, input logic st, input logic [63:0] pc);
    isq_payload_t p;
    p = '0;
    p.rs1 = rs1; p.rs2 = rs2; p.rd = 5'd10;
    p.src1 = s1; p.src2 = s2; p.offset = pc + 64'h4;
    p.src1_is_reg = 1'b1; p.src2_is_reg = 1'b1; p.need_to_wb = !st;
    p.cx_type = 3'd1; p.alu_type = 4'd2; p.muldiv_type = 3'd0;
    p.is_load = ld; p.is_store = st; p.size = 4'd8; p.pc = pc;
    p.instr = pc[31:0] ^ 32'h13;
    return p;
  endfunction

  task automatic put(input isq_payload_t p, input logic r1, input logic r2);
    e_pay = p; e_r1 = r1; e_r2 = r2; enq_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_issue_src1", issue_src1, 64'd0);
    reset_n = 1'b1;

    // Simple add: ready operands 5 and 7, issued the cycle after enqueue
    issue_ready = 1'b1;
    put(mk(5'd1, 5'd2, 64'd5, 64'd7, 0, 0, 64'h8), 1, 1);
    tick();
    enq_valid = 1'b0;
    check("add_valid", 64'(issue_valid), 64'd1);
    check("add_src1", issue_src1, 64'd5);
    check("add_src2", issue_src2, 64'd7);
    tick();
    check("add_empty", 64'(issue_valid), 64'd0);

    // Younger ready op passes an older waiting one; wakeup then releases it
    issue_ready = 1'b0;
    put(mk(5'd3, 5'd0, 64'h99, 64'h44, 0, 0, 64'h10), 0, 0);
    tick();
    put(mk(5'd1, 5'd2, 64'd1, 64'd2, 0, 0, 64'h20), 1, 1);
    tick();
    enq_valid = 1'b0;
    issue_ready = 1'b1;
    check("ooo_first_pc", issue_pc, 64'h20);
    tick();
    check("ooo_a_waits", 64'(issue_valid), 64'd0);
    wb(5'd3, 64'hDEAD);
    check("ooo_no_bypass", 64'(issue_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    check("wake_valid", 64'(issue_valid), 64'd1);
    check("wake_src1", issue_src1, 64'hDEAD);
    check("wake_src2_x0", issue_src2, 64'd0);
    check("wake_pc", issue_pc, 64'h10);
    tick();

    // Enqueue-time bypass, x0 operand reads zero
    put(mk(5'd0, 5'd9, 64'h77, 64'h0, 0, 0, 64'h30), 0, 0);
    wb(5'd9, 64'h11);
    tick();
    enq_valid = 1'b0; wb_valid = 1'b0;
    check("byp_valid", 64'(issue_valid), 64'd1);
    check("byp_src1", issue_src1, 64'd0);
    check("byp_src2", issue_src2, 64'h11);
    tick();
    // wb to x0 wakes nothing
    put(mk(5'd5, 5'd6, 64'h5, 64'h0, 0, 0, 64'h40), 1, 0);
    tick();
    enq_valid = 1'b0;
    wb(5'd0, 64'h55);
    check("x0_wait", 64'(issue_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    check("x0_nowake", 64'(issue_valid), 64'd0);
    wb(5'd6, 64'h66);
    tick();
    wb_valid = 1'b0;
    check("r6_wake_src2", issue_src2, 64'h66);
    tick();

    // Fill to full, then drain one per cycle while dispatch keeps offering
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      put(mk(5'd1, 5'd2, 64'(i), 64'(i + 1), 0, 0, 64'h100 + 64'(i)), 1, 1);
      tick();
    end
    put(mk(5'd1, 5'd2, 64'hA, 64'hB, 0, 0, 64'h1F0), 1, 1);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    tick();
    check("full_still", 64'(enq_ready), 64'd0);
    issue_ready = 1'b1;
    check("full_ready_ignored", 64'(enq_ready), 64'd0);
    check("full_head_pc", issue_pc, 64'h100);
    tick();
    check("drain_enq_ready", 64'(enq_ready), 64'd1);
    check("drain_next_pc", issue_pc, 64'h101);
    hs_snap = hs_count;
    repeat (4) tick();
    check("one_issue_per_cycle", 64'(hs_count - hs_snap), 64'd4);
    enq_valid = 1'b0;
    repeat (10) tick();
    check("drained", 64'(issue_valid), 64'd0);

    // Memory ordering: waiting load blocks a younger store, not an ALU op
    issue_ready = 1'b0;
    put(mk(5'd12, 5'd0, 64'h0, 64'h0, 1, 0, 64'h200), 0, 0);
    tick();
    put(mk(5'd1, 5'd2, 64'h3, 64'h4, 0, 1, 64'h210), 1, 1);
    tick();
    put(mk(5'd1, 5'd2, 64'h5, 64'h6, 0, 0, 64'h220), 1, 1);
    tick();
    enq_valid = 1'b0;
    issue_ready = 1'b1;
    check("mem_alu_first", issue_pc, 64'h220);
    tick();
    check("mem_store_blocked", 64'(issue_valid), 64'd0);
    wb(5'd12, 64'hABC);
    tick();
    wb_valid = 1'b0;
    check("mem_load_pc", issue_pc, 64'h200);
    check("mem_load_src1", issue_src1, 64'hABC);
    tick();
    check("mem_store_pc", issue_pc, 64'h210);
    tick();
    check("mem_empty", 64'(issue_valid), 64'd0);

    // Flush with simultaneous enqueue and issue
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(mk(5'd1, 5'd2, 64'd1, 64'd2, 0, 0, 64'h400 + 64'(i)), 1, 1);
      tick();
    end
    put(mk(5'd1, 5'd2, 64'd1, 64'd2, 0, 0, 64'h4F0), 1, 1);
    issue_ready = 1'b1;
    flush = 1'b1;
    check("pre_flush_valid", 64'(issue_valid), 64'd1);
    hs_snap = hs_count;
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_enq_ready", 64'(enq_ready), 64'd1);
    check("flush_no_handshake", 64'(hs_count - hs_snap), 64'd0);
    tick();

    // Reset mid-traffic; first enqueue after release is accepted at once
    issue_ready = 1'b0;
    put(mk(5'd1, 5'd2, 64'd1, 64'd2, 0, 0, 64'h500), 1, 1);
    tick();
    tick();
    enq_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(issue_valid), 64'd0);
    tick();
    put(mk(5'd1, 5'd2, 64'd3, 64'd4, 0, 0, 64'h300), 1, 1);
    reset_n = 1'b1;
    tick();
    enq_valid = 1'b0;
    check("post_rst_valid", 64'(issue_valid), 64'd1);
    check("post_rst_pc", issue_pc, 64'h300);
    issue_ready = 1'b1;
    tick();
    check("post_rst_empty", 64'(issue_valid), 64'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
